// File: rtl/fifo_async_read_arbiter.sv
// Round-robin arbiter sharing one async FIFO read port among NREQ consumers.
// Ports: read_clk/nrst_in, req_in, grant_out, fifo_empty_in, fifo_data_in,
//        fifo_read_out, data_out, valid_out, done_out.
module fifo_async_read_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int BURST = 4
) (
    input  logic             read_clk,
    input  logic             nrst_in,
    input  logic [NREQ-1:0]  req_in,
    output logic [NREQ-1:0]  grant_out,
    input  logic             fifo_empty_in,
    input  logic [WIDTH-1:0] fifo_data_in,
    output logic             fifo_read_out,
    output logic [WIDTH-1:0] data_out,
    output logic [NREQ-1:0]  valid_out,
    output logic             done_out
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(BURST + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [NREQ-1:0] r_grant;
    logic [IW-1:0]   r_gidx;
    logic [IW-1:0]   r_ptr;
    logic [CW-1:0]   r_cnt;
    logic [NREQ-1:0] r_valid;
    logic            r_done;
    logic            w_rd;
    logic            w_found;
    logic [IW-1:0]   w_pick;
    logic [IW-1:0]   w_idx;
    logic            w_last;

    // Round-robin search starts just after the last served consumer.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            w_idx = IW'((int'(r_ptr) + i) % NREQ);
            if (!w_found && req_in[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rd        = 1'b0;
        // The strobe taken at count BURST-1 is the final one of the burst.
        w_last      = (r_cnt == CW'(BURST - 1));
        unique case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt = READ;
                end
            end
            READ: begin
                w_rd = !fifo_empty_in && req_in[r_gidx]
                       && (r_cnt != CW'(BURST));
                if (!req_in[r_gidx] || (w_rd && w_last)) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge read_clk) begin
        if (!nrst_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge read_clk) begin
        if (!nrst_in) begin
            r_grant <= '0;
            r_gidx  <= '0;
            r_ptr   <= IW'(NREQ - 1);
            r_cnt   <= '0;
            r_valid <= '0;
            r_done  <= 1'b0;
        end else begin
            // Read data lands one cycle after the strobe; tag it then.
            r_valid <= w_rd ? r_grant : '0;
            r_done  <= (r_state == DRAIN);
            if (r_state == IDLE) begin
                r_cnt <= '0;
                if (w_found) begin
                    r_grant <= {{(NREQ-1){1'b0}}, 1'b1} << w_pick;
                    r_gidx  <= w_pick;
                end else begin
                    r_grant <= '0;
                end
            end else if (r_state == READ) begin
                if (w_rd) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                // Pointer advances even on an empty burst to avoid starvation.
                r_grant <= '0;
                r_ptr   <= r_gidx;
            end
        end
    end

    assign grant_out     = r_grant;
    assign fifo_read_out = w_rd;
    assign data_out      = fifo_data_in;
    assign valid_out     = r_valid;
    assign done_out      = r_done;

endmodule
